// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared types, widths and arithmetic helpers for the psum collector
package pe_array_pkg;

  localparam int TOP_BITS_C   = 2;
  localparam int BOT_BITS_C   = 14;
  localparam int DATA_WIDTH_C = TOP_BITS_C + BOT_BITS_C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } collector_state_e;

  // Number of valid-convolution outputs for one layer.
  function automatic int out_count(input int height, input int width, input int kernel);
    return (height - kernel + 1) * (width - kernel + 1);
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      return hi[31:0];
    end else if (sum < lo) begin
      return lo[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// rtl/psum_fifo.sv - first-word-fall-through FIFO; a push into a full FIFO without a pop is dropped
module psum_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // A pop frees the head slot this cycle, so a push at full still fits.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    pop   = out_tready && !empty;
    push  = in_tvalid && (!full || pop);
    drop  = in_tvalid && full && !pop;
  end

  assign out_tvalid = !empty;
  assign out_tdata  = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_tdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - bias-add, saturate, quantise and buffer final psums into the ofmap buffer
// Optional ReLU on the saturated result when PSUM_RELU_EN is defined.
module psum_collector
  import pe_array_pkg::*;
#(
  parameter int G_BUF_ADDR_WIDTH = 10,
  parameter int G_BUF_DATA_WIDTH = 8,
  parameter int G_TOP_BITS       = TOP_BITS_C,
  parameter int G_BOT_BITS       = BOT_BITS_C,
  parameter int G_KERNEL_SIZE    = 5,
  parameter int G_IMAGE_HEIGHT   = 28,
  parameter int G_IMAGE_WIDTH    = 28,
  parameter int G_FIFO_DEPTH     = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [G_BUF_ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [G_TOP_BITS+G_BOT_BITS-1:0]   bias_i,
  input  logic                               psum_vld_i,
  input  logic [G_TOP_BITS+G_BOT_BITS-1:0]   psum_i,
  input  logic                               buf_rdy_i,
  output logic                               buf_wr_en_o,
  output logic [G_BUF_ADDR_WIDTH-1:0]        buf_addr_o,
  output logic [G_BUF_DATA_WIDTH-1:0]        buf_wdata_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               overflow_o
);

  localparam int D         = G_TOP_BITS + G_BOT_BITS;
  localparam int OUT_COUNT = out_count(G_IMAGE_HEIGHT, G_IMAGE_WIDTH, G_KERNEL_SIZE);
  localparam int CNT_W     = $clog2(OUT_COUNT + 1);

  collector_state_e              state_q;
  logic                          s1_vld_q;
  logic [D-1:0]                  s1_data_q;
  logic signed [31:0]            sum_sat;
  logic [G_BUF_DATA_WIDTH-1:0]   quant;
  logic                          fifo_vld;
  logic                          fifo_drop;
  logic                          accept;
  logic                          run_psum;
  logic [G_BUF_ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]              wr_cnt_q;

  assign run_psum = psum_vld_i && (state_q == ST_RUN);

  always_comb begin
    sum_sat = sat_add(32'(signed'(psum_i)), 32'(signed'(bias_i)), D);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= run_psum;
      if (run_psum) begin
        s1_data_q <= sum_sat[D-1:0];
      end
    end
  end

  // Keep the integer bits and the leading fraction bits; the rest is truncated.
  always_comb begin
    quant = s1_data_q[D-1 -: G_BUF_DATA_WIDTH];
`ifdef PSUM_RELU_EN
    if (s1_data_q[D-1]) begin
      quant = '0;
    end
`endif
  end

  psum_fifo #(
    .WIDTH (G_BUF_DATA_WIDTH),
    .DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_tdata   (quant),
    .in_tvalid  (s1_vld_q),
    .out_tdata  (buf_wdata_o),
    .out_tvalid (fifo_vld),
    .out_tready (buf_rdy_i),
    .drop       (fifo_drop)
  );

  assign buf_wr_en_o = fifo_vld;
  assign accept      = fifo_vld && buf_rdy_i;
  assign buf_addr_o  = addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_cnt_q   <= '0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= addr_q + G_BUF_ADDR_WIDTH'(1);
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      if (fifo_drop) begin
        overflow_o <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            addr_q     <= base_addr_i;
            wr_cnt_q   <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept && (wr_cnt_q == CNT_W'(OUT_COUNT - 1))) begin
            state_q <= ST_DONE;
            done_o  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - directed scoreboard bench for psum_collector
module tb_psum_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] bias;
  logic        psum_vld;
  logic [15:0] psum;
  logic        buf_rdy;
  logic        buf_wr_en;
  logic [9:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        busy;
  logic        done;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_d;
  logic [9:0]  exp_addr = '0;
  int          wr_count = 0;
  int          done_count = 0;
  int          last_wr_cyc = 0;
  logic [7:0]  last_wdata = '0;
  logic [9:0]  addr_log[1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psum_collector dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .bias_i      (bias),
    .psum_vld_i  (psum_vld),
    .psum_i      (psum),
    .buf_rdy_i   (buf_rdy),
    .buf_wr_en_o (buf_wr_en),
    .buf_addr_o  (buf_addr),
    .buf_wdata_o (buf_wdata),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_q(input logic [15:0] p, input logic [15:0] b);
    int s;
    s = int'($signed(p)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef PSUM_RELU_EN
    if (s < 0) s = 0;
`endif
    return 8'(s >>> 8);
  endfunction

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    psum_vld = 1'b1;
    psum     = p;
    exp_q.push_back(model_q(p, bias));
    drive();
    psum_vld = 1'b0;
  endtask

  task automatic start_layer(input logic [9:0] b_addr, input logic [15:0] b);
    drive();
    base_addr = b_addr;
    bias      = b;
    start     = 1'b1;
    exp_addr  = b_addr;
    wr_count  = 0;
    drive();
    start = 1'b0;
  endtask

  task automatic do_reset();
    drive();
    rst = 1'b1;
    drive();
    rst = 1'b0;
    exp_q.delete();
    wr_count = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_wr_en"}, buf_wr_en, 0);
    chk({tag, "_addr"}, buf_addr, 0);
    chk({tag, "_wdata"}, buf_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("write_count", wr_count, n);
  endtask

  // Scoreboard: every accepted write is compared against the next queued expectation.
  always @(negedge clk) begin
    if (!rst && buf_wr_en && buf_rdy) begin
      chk("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        chk("wdata", buf_wdata, exp_d);
      end
      chk("waddr", buf_addr, exp_addr);
      if (wr_count < 1024) addr_log[wr_count] = buf_addr;
      last_wdata  = buf_wdata;
      last_wr_cyc = cyc;
      wr_count++;
      exp_addr++;
    end
    if (!rst && done) done_count++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; base_addr = '0; bias = '0;
    psum_vld = 1'b0; psum = '0; buf_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    drive();
    rst = 1'b0;

    // Basic path and two-cycle latency
    start_layer(10'h000, 16'h0100);
    @(negedge clk);
    chk("busy_run", busy, 1);
    chk("done_run", done, 0);
    psum_vld = 1'b1;
    psum     = 16'h4000;
    exp_q.push_back(model_q(16'h4000, 16'h0100));
    drive();
    psum_vld = 1'b0;
    @(negedge clk);
    chk("lat1_wr_en", buf_wr_en, 0);
    @(negedge clk);
    chk("lat2_wr_en", buf_wr_en, 1);
    chk("lat2_addr", buf_addr, 10'h000);
    chk("lat2_wdata", buf_wdata, 8'h41);
    send(16'h7F00);
    send(16'hC000);
    send(16'h8000);
    wait_writes(4, 20);

    // Saturation and sign handling
    do_reset();
    start_layer(10'h000, 16'h2000);
    send(16'h7000);
    wait_writes(1, 20);
    chk("sat_pos", last_wdata, 8'h7F);
    do_reset();
    start_layer(10'h000, 16'hF000);
    send(16'h8000);
    wait_writes(1, 20);
`ifdef PSUM_RELU_EN
    chk("sat_neg", last_wdata, 8'h00);
`else
    chk("sat_neg", last_wdata, 8'h80);
`endif
    do_reset();
    start_layer(10'h000, 16'h0000);
    send(16'hC000);
    wait_writes(1, 20);
`ifdef PSUM_RELU_EN
    chk("relu", last_wdata, 8'h00);
`else
    chk("relu", last_wdata, 8'hC0);
`endif
    chk("no_done_aborted", done_count, 0);

    // Full layer with address wrap and completion
    do_reset();
    done_count = 0;
    start_layer(10'h3F0, 16'h1234);
    for (int i = 0; i < 576; i++) begin
      send(16'($urandom_range(0, 65535)));
    end
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
    chk("done_cycle", cyc, last_wr_cyc + 1);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("done_fall", done, 0);
    chk("busy_fall", busy, 0);
    chk("wrap_first", addr_log[0], 10'h3F0);
    chk("wrap_top", addr_log[15], 10'h3FF);
    chk("wrap_zero", addr_log[16], 10'h000);
    chk("wrap_last", addr_log[575], 10'h22F);
    chk("layer_writes", wr_count, 576);
    repeat (5) @(negedge clk);
    chk("done_once", done_count, 1);
    chk("layer_queue_empty", exp_q.size(), 0);

    // Back-pressure, overflow and push+pop at full
    do_reset();
    buf_rdy = 1'b0;
    start_layer(10'h100, 16'h0000);
    send(16'h1100);
    send(16'h2200);
    send(16'h3300);
    send(16'h0400);
    psum_vld = 1'b1;
    psum     = 16'h5500;
    drive();
    psum_vld = 1'b0;
    @(negedge clk);
    chk("ovf_before", overflow, 0);
    drive();
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("bp_wr_en", buf_wr_en, 1);
    chk("bp_addr_hold", buf_addr, 10'h100);
    chk("bp_wdata_hold", buf_wdata, 8'h11);
    send(16'h0600);
    buf_rdy = 1'b1;
    drive();
    buf_rdy = 1'b0;
    @(negedge clk);
    chk("full_pp_writes", wr_count, 1);
    chk("full_pp_addr", buf_addr, 10'h101);
    chk("full_pp_wdata", buf_wdata, 8'h22);
    drive();
    buf_rdy = 1'b1;
    wait_writes(5, 20);
    chk("ovf_sticky", overflow, 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a layer
    do_reset();
    done_count = 0;
    start_layer(10'h050, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      send(16'($urandom_range(0, 65535)));
    end
    wait_writes(100, 50);
    drive();
    rst = 1'b1;
    drive();
    @(negedge clk);
    check_zero_outputs("midrst");
    drive();
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("midrst_no_done", done_count, 0);
    start_layer(10'h200, 16'h0000);
    send(16'h1000);
    wait_writes(1, 20);
    chk("restart_addr", addr_log[0], 10'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- G_BUF_ADDR_WIDTH, 10, ofmap buffer address width
- G_BUF_DATA_WIDTH, 8, ofmap buffer data width
- G_TOP_BITS, 2, integer bits of the signed fixed-point psum
- G_BOT_BITS, 14, fraction bits of the signed fixed-point psum
- G_KERNEL_SIZE, 5, kernel edge
- G_IMAGE_HEIGHT, 28, ifmap height
- G_IMAGE_WIDTH, 28, ifmap width
- G_FIFO_DEPTH, 4, output FIFO entries (power of two)
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk_i, in, 1, clock
- rst_i, in, 1, synchronous active-high reset
- start_i, in, 1, begin a layer
- base_addr_i, in, G_BUF_ADDR_WIDTH, first ofmap address
- bias_i, in, D=G_TOP_BITS+G_BOT_BITS, bias; held stable during RUN
- psum_vld_i, in, 1, psum strobe from the last PE row
- psum_i, in, D, signed final psum
- buf_rdy_i, in, 1, buffer accepts a write
- buf_wr_en_o, out, 1, write request
- buf_addr_o, out, G_BUF_ADDR_WIDTH, write address
- buf_wdata_o, out, G_BUF_DATA_WIDTH, write data
- busy_o, out, 1, state is not IDLE
- done_o, out, 1, one-cycle layer-complete pulse
- overflow_o, out, 1, sticky psum-dropped flag

Function
REQ-003 OUT_COUNT SHALL be (G_IMAGE_HEIGHT-G_KERNEL_SIZE+1)*(G_IMAGE_WIDTH-G_KERNEL_SIZE+1), i.e. 576 at the defaults.
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN: on start_i. Latch base_addr_i, clear the write index and overflow_o.
- RUN to DONE: when the OUT_COUNT-th write is accepted.
- DONE to IDLE: unconditionally, after one cycle.
REQ-005 start_i SHALL be ignored outside IDLE. psum_vld_i SHALL be ignored in IDLE and DONE.
REQ-006 Stage 1 SHALL register, per valid psum, sat(psum_i + bias_i) as a D-bit signed two's-complement value, saturating to 0x7FFF/0x8000 at the defaults.
REQ-007 The stage-1 result SHALL be quantised to its top G_BUF_DATA_WIDTH bits by truncation (Q2.6 at the defaults) and pushed into the output FIFO on the next cycle.
REQ-008 The FIFO SHALL be first-word-fall-through. buf_wr_en_o SHALL equal FIFO not-empty. A write is accepted when buf_wr_en_o and buf_rdy_i are both high.
REQ-009 Latency from psum_vld_i to buf_wr_en_o SHALL be exactly 2 cycles when the FIFO is empty.
REQ-010 buf_addr_o SHALL equal (base + write index) modulo 2^G_BUF_ADDR_WIDTH, wrapping silently. The index SHALL increment once per accepted write.
REQ-011 A push and a pop in the same cycle SHALL be legal at any occupancy, including full, with no loss.
REQ-012 A push into a full FIFO without a simultaneous pop SHALL drop the sample and set overflow_o. overflow_o SHALL stay set until start_i or reset.
REQ-013 buf_rdy_i low SHALL hold buf_addr_o and buf_wdata_o stable.
REQ-014 busy_o SHALL be high in RUN and DONE. done_o SHALL be high only in DONE.

Reset
REQ-015 rst_i SHALL force IDLE, empty the FIFO and clear stage 1, the index and the base.
REQ-016 While and after rst_i, every output SHALL be 0, including buf_addr_o and buf_wdata_o.
REQ-017 A reset during RUN SHALL abort the layer with no done_o pulse.

Configuration
REQ-018 With PSUM_RELU_EN defined, a negative saturated result SHALL be replaced by 0 before quantisation.
REQ-019 Without PSUM_RELU_EN, the signed value SHALL pass through unchanged.

Structure
REQ-020 Package pe_array_pkg SHALL hold:
- DATA_WIDTH_C
- the collector state enum
- a saturating-add function
- the OUT_COUNT computation
REQ-021 The FIFO SHALL be a separate sub-module, psum_fifo, parameterised by width and depth.

Verification
REQ-022 Basic path: start_i with base 0x000, bias 0x0100, psum_i 0x4000, buf_rdy_i high -> 2 cycles later buf_wr_en_o=1, buf_addr_o=0x000, buf_wdata_o=0x41.
REQ-023 Saturation: psum_i 0x7000 with bias 0x2000 -> buf_wdata_o=0x7F. psum_i 0x8000 with bias 0xF000 -> 0x80 without PSUM_RELU_EN.
REQ-024 ReLU: psum_i 0xC000 with bias 0 -> 0x00 with PSUM_RELU_EN, 0xC0 without it.
REQ-025 Wrap and completion: base 0x3F0, 576 psums, buf_rdy_i high.
- Addresses run 0x3F0 to 0x3FF, then 0x000 to 0x22F.
- done_o pulses once, one cycle after the 576th write.
- busy_o falls the same cycle done_o falls.
REQ-026 Back-pressure: buf_rdy_i low while 5 psums arrive.
- 4 are buffered and overflow_o=1.
- After buf_rdy_i rises, 4 writes issue in order.
- A push and pop in the same cycle at full loses nothing.
REQ-027 Reset mid-layer: assert rst_i after 100 writes.
- All outputs read 0 on the next cycle.
- No done_o pulse.
- A following start_i restarts addressing at the new base.
